// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-stage state encoding, the NOP word and the primary opcodes
// decoded downstream.
package cpu_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StExec  = 2'd2,
        StErr   = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    function automatic logic is_known_op(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_SLTI, OP_J};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC selection for the executing instruction: jump, taken branch, or fall-through.
module npc_calc (
    input  logic [31:0] pc_plus4,
    input  logic [25:0] ir_low,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic [31:0] jump_target;
    logic [31:0] branch_target;

    assign jump_target   = {pc_plus4[31:28], ir_low, 2'b00};
    assign branch_target = pc_plus4 + {{14{ir_low[15]}}, ir_low[15:0], 2'b00};

    // Jump wins over Branch when control asserts both.
    always_comb begin
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = jump_target;
        end else if (Branch && zero) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a ready handshake into the instruction
// register and holds it for the decoder until the stage is released.
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned TO_W     = 5
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ready,
    input  logic [31:0] inst_in,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        zero,
    input  logic        stall,
    output logic [31:0] inst_out,
    output logic [5:0]  OPcode,
    output logic [5:0]  Fun,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    output logic        fetch_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    fetch_state_e    state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [31:0]     next_pc;

    npc_calc u_npc_calc (
        .pc_plus4 (pc_plus4),
        .ir_low   (ir_q[25:0]),
        .Branch   (Branch),
        .Jump     (Jump),
        .zero     (zero),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= NOP;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
                cnt_d   = '0;
            end
            StFetch: begin
                // A response on the last allowed cycle still counts as a hit.
                if (inst_ready) begin
                    ir_d    = inst_in;
                    cnt_d   = '0;
                    state_d = StExec;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            StExec: begin
                if (!stall) begin
                    pc_d    = next_pc;
                    state_d = StFetch;
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign inst_req   = (state_q == StFetch);
    assign inst_valid = (state_q == StExec);
    assign inst_addr  = pc_q;
    assign pc_out     = pc_q;
    assign pc_plus4   = pc_q + 32'd4;
    assign inst_out   = ir_q;
    assign OPcode     = ir_q[31:26];
    assign Fun        = ir_q[5:0];
    assign fetch_err  = err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios then randomized traffic, all
// compared every cycle against a transaction-level model of the fetch stage.
module tb_inst_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int unsigned TO  = 8;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ready;
    logic [31:0] inst_in;
    logic        Branch;
    logic        Jump;
    logic        zero;
    logic        stall;
    logic [31:0] inst_out;
    logic [5:0]  OPcode;
    logic [5:0]  Fun;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        inst_valid;
    logic        fetch_err;

    int n_checks = 0;
    int n_errors = 0;

    inst_fetch_unit #(
        .RESET_PC (RPC),
        .TIMEOUT  (TO),
        .TO_W     (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_ready (inst_ready),
        .inst_in    (inst_in),
        .Branch     (Branch),
        .Jump       (Jump),
        .zero       (zero),
        .stall      (stall),
        .inst_out   (inst_out),
        .OPcode     (OPcode),
        .Fun        (Fun),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .inst_valid (inst_valid),
        .fetch_err  (fetch_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Model: mode 0 = waiting to start, 1 = fetching, 2 = holding an instruction, 3 = dead.
    int          m_mode = 0;
    int          m_wait = 0;
    logic [31:0] m_pc   = RPC;
    logic [31:0] m_ir   = 32'h0;
    logic        m_err  = 1'b0;

    function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [31:0] ir,
                                              input logic br, input logic jp, input logic z);
        logic [31:0] p4;
        int          off;
        p4 = pc + 32'd4;
        if (jp) return (p4 & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) * 4);
        if (br && z) begin
            off = int'($signed(ir[15:0]));
            return p4 + 32'(off * 4);
        end
        return p4;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0;
            m_wait <= 0;
            m_pc   <= RPC;
            m_ir   <= 32'h0;
            m_err  <= 1'b0;
        end else begin
            case (m_mode)
                0: begin
                    m_mode <= 1;
                    m_wait <= 0;
                end
                1: begin
                    if (inst_ready) begin
                        m_ir   <= inst_in;
                        m_mode <= 2;
                    end else if (m_wait + 1 == int'(TO)) begin
                        m_mode <= 3;
                        m_err  <= 1'b1;
                    end else begin
                        m_wait <= m_wait + 1;
                    end
                end
                2: begin
                    if (!stall) begin
                        m_pc   <= model_npc(m_pc, m_ir, Branch, Jump, zero);
                        m_mode <= 1;
                        m_wait <= 0;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        check("inst_req", 32'(inst_req), 32'(m_mode == 1));
        check("inst_valid", 32'(inst_valid), 32'(m_mode == 2));
        check("fetch_err", 32'(fetch_err), 32'(m_err));
        check("inst_addr", inst_addr, m_pc);
        check("pc_out", pc_out, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("inst_out", inst_out, m_ir);
        check("OPcode", 32'(OPcode), 32'(m_ir[31:26]));
        check("Fun", 32'(Fun), 32'(m_ir[5:0]));
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic do_fetch(input logic [31:0] w, input int waits);
        repeat (waits) begin
            inst_ready = 1'b0;
            inst_in    = $urandom;
            tick();
        end
        inst_ready = 1'b1;
        inst_in    = w;
        tick();
        inst_ready = 1'b0;
        inst_in    = $urandom;
    endtask

    task automatic exec_go(input logic br, input logic jp, input logic z);
        Branch = br;
        Jump   = jp;
        zero   = z;
        stall  = 1'b0;
        tick();
        Branch = 1'b0;
        Jump   = 1'b0;
        zero   = 1'b0;
    endtask

    initial begin
        int pct;
        rst        = 1'b1;
        inst_ready = 1'b0;
        inst_in    = 32'h0;
        Branch     = 1'b0;
        Jump       = 1'b0;
        zero       = 1'b0;
        stall      = 1'b0;
        repeat (2) tick();
        check("rst pc_out", pc_out, 32'h0);
        check("rst inst_req", 32'(inst_req), 32'h0);
        check("rst inst_valid", 32'(inst_valid), 32'h0);
        check("rst fetch_err", 32'(fetch_err), 32'h0);

        rst = 1'b0;
        #1;
        check("idle inst_req", 32'(inst_req), 32'h0);
        tick();
        check("first req", 32'(inst_req), 32'h1);
        check("first addr", inst_addr, 32'h0);

        do_fetch(32'h0085_1020, 2);
        check("add valid", 32'(inst_valid), 32'h1);
        check("add OPcode", 32'(OPcode), 32'h00);
        check("add Fun", 32'(Fun), 32'h20);
        exec_go(1'b0, 1'b0, 1'b0);
        check("add valid drop", 32'(inst_valid), 32'h0);
        check("seq addr", inst_addr, 32'h4);

        for (int i = 0; i < 3; i++) begin
            do_fetch(32'h0, 0);
            exec_go(1'b0, 1'b0, 1'b0);
        end
        check("beq addr", inst_addr, 32'h10);
        do_fetch(32'h1000_FFFF, 1);
        exec_go(1'b1, 1'b0, 1'b1);
        check("beq taken", inst_addr, 32'h10);
        do_fetch(32'h1000_FFFF, 0);
        exec_go(1'b1, 1'b0, 1'b0);
        check("beq not taken", inst_addr, 32'h14);

        for (int i = 0; i < 3; i++) begin
            do_fetch(32'h0, 0);
            exec_go(1'b0, 1'b0, 1'b0);
        end
        check("j addr", inst_addr, 32'h20);
        do_fetch(32'h0800_0100, 0);
        exec_go(1'b0, 1'b1, 1'b0);
        check("j target", inst_addr, 32'h400);
        do_fetch(32'h0800_0100, 0);
        exec_go(1'b1, 1'b1, 1'b1);
        check("j priority", inst_addr, 32'h400);

        do_fetch(32'h0, 0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall valid", 32'(inst_valid), 32'h1);
            check("stall pc", pc_out, 32'h400);
            check("stall req", 32'(inst_req), 32'h0);
            tick();
        end
        check("stall last valid", 32'(inst_valid), 32'h1);
        exec_go(1'b0, 1'b0, 1'b0);
        check("post stall valid", 32'(inst_valid), 32'h0);
        check("post stall addr", inst_addr, 32'h404);

        inst_ready = 1'b0;
        for (int i = 0; i < int'(TO); i++) begin
            check("to req", 32'(inst_req), 32'h1);
            check("to err early", 32'(fetch_err), 32'h0);
            tick();
        end
        repeat (3) begin
            check("to err", 32'(fetch_err), 32'h1);
            check("to req dead", 32'(inst_req), 32'h0);
            inst_ready = 1'b1;
            tick();
        end
        inst_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("err rst clear", 32'(fetch_err), 32'h0);
        check("err rst pc", pc_out, RPC);
        tick();
        rst = 1'b0;

        pct = 75;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 500 == 0) pct = 15 + int'($urandom_range(0, 3)) * 20;
            inst_ready = ($urandom_range(0, 99) < pct);
            inst_in    = $urandom;
            if ($urandom_range(0, 3) == 0) inst_in[31:26] = 6'b000010;
            if ($urandom_range(0, 3) == 0) inst_in[31:26] = 6'b000100;
            Branch = $urandom_range(0, 1);
            Jump   = ($urandom_range(0, 4) == 0);
            zero   = $urandom_range(0, 1);
            stall  = ($urandom_range(0, 2) == 0);
            if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
